instr_loader: RTL

//  Upstream stage of the cpu core. Assembles 9-bit instructions from 3-bit pin chunks and

---
 rtl/instr_loader_pkg.sv | 15 +
 rtl/loader_fifo.sv | 49 ++++
 rtl/instr_loader.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/instr_loader_pkg.sv
// Shared constants and issue-state encoding for the instruction loader.
// Optional parity checking is enabled with INSTR_LOADER_PARITY_EN.
package instr_loader_pkg;

  localparam int INSTR_W = 9;
  localparam int CHUNK_W = 3;
  localparam int CHUNKS  = INSTR_W / CHUNK_W;
  localparam int DEPTH   = 4;

  typedef enum logic {
    IDLE,
    ISSUE
  } issue_st_t;

endpackage

// File: rtl/loader_fifo.sv
// Instruction FIFO for instr_loader: extra-MSB pointers, flush clears
// both pointers, head is read combinationally at the read pointer.
module loader_fifo #(
  parameter int W     = 9,
  parameter int DEPTH = 4
) (
  input  logic                   CLK,
  input  logic                   RESET_N,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [W-1:0]           wdata,
  output logic [W-1:0]           rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr;
  logic [AW:0]  rptr;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  // Storage carries no reset; only pointer-covered entries are read.
  always_ff @(posedge CLK) begin
    if (push) mem[wptr[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rptr[AW-1:0]];
  assign count = wptr - rptr;
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) &&
                 (wptr[AW-1:0] == rptr[AW-1:0]);

endmodule

// File: rtl/instr_loader.sv
// Chunk assembler, instruction FIFO and write_en issue FSM.
// Define INSTR_LOADER_PARITY_EN to add DIN_PAR / PAR_ERR checking.
module instr_loader #(
  parameter int INSTR_W = instr_loader_pkg::INSTR_W,
  parameter int CHUNK_W = instr_loader_pkg::CHUNK_W,
  parameter int DEPTH   = instr_loader_pkg::DEPTH
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic [CHUNK_W-1:0] DIN,
  input  logic               DIN_VALID,
`ifdef INSTR_LOADER_PARITY_EN
  input  logic               DIN_PAR,
  output logic               PAR_ERR,
`endif
  input  logic               FLUSH,
  input  logic               CPU_READY,
  output logic [INSTR_W-1:0] INSTRUCTION,
  output logic               write_en,
  output logic               FULL,
  output logic               EMPTY,
  output logic               ERR
);
  import instr_loader_pkg::*;

  localparam int NCH = INSTR_W / CHUNK_W;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int AW  = $clog2(DEPTH);

  if ((INSTR_W % CHUNK_W) != 0 || DEPTH < 2 ||
      (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_cfg
    $error("instr_loader: illegal INSTR_W/CHUNK_W/DEPTH");
  end

  logic [INSTR_W-1:0] shift;
  logic [INSTR_W-1:0] word;
  logic [INSTR_W-1:0] head;
  logic [CW-1:0]      cnt;
  logic [AW:0]        count;
  logic               last;
  logic               par_ok;
  logic               push_req;
  logic               push_ok;
  logic               pop;
  logic               room;
  issue_st_t          state;

  assign word     = INSTR_W'({shift, DIN});
  assign last     = (cnt == CW'(NCH - 1));
  assign pop      = !FLUSH && !EMPTY && CPU_READY;
  assign room     = (count != (AW + 1)'(DEPTH));
  assign push_req = !FLUSH && DIN_VALID && last && par_ok;
  assign push_ok  = push_req && (room || pop);

`ifdef INSTR_LOADER_PARITY_EN
  assign par_ok = ~^{word, DIN_PAR};

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)
      PAR_ERR <= 1'b0;
    else if (FLUSH)
      PAR_ERR <= 1'b0;
    else if (DIN_VALID && last && !par_ok)
      PAR_ERR <= 1'b1;
  end
`else
  assign par_ok = 1'b1;
`endif

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt   <= '0;
      shift <= '0;
      ERR   <= 1'b0;
    end else if (FLUSH) begin
      cnt   <= '0;
      shift <= '0;
      ERR   <= 1'b0;
    end else begin
      if (DIN_VALID) begin
        shift <= word;
        cnt   <= last ? '0 : cnt + 1'b1;
      end
      if (push_req && !push_ok) ERR <= 1'b1;
    end
  end

  loader_fifo #(
    .W     (INSTR_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .push    (push_ok),
    .pop     (pop),
    .flush   (FLUSH),
    .wdata   (word),
    .rdata   (head),
    .full    (FULL),
    .empty   (EMPTY),
    .count   (count)
  );

  // INSTRUCTION is only loaded on a pop, so it holds between pulses.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state       <= IDLE;
      write_en    <= 1'b0;
      INSTRUCTION <= '0;
    end else if (FLUSH) begin
      state    <= IDLE;
      write_en <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          write_en <= 1'b0;
          if (pop) begin
            state       <= ISSUE;
            write_en    <= 1'b1;
            INSTRUCTION <= head;
          end
        end
        ISSUE: begin
          if (pop) begin
            write_en    <= 1'b1;
            INSTRUCTION <= head;
          end else begin
            state    <= IDLE;
            write_en <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          write_en <= 1'b0;
        end
      endcase
    end
  end

endmodule
